// File: rtl/timer_tick_sequencer.sv
// Avalon-MM master sequencing the interval timer's s1 slave: programs the period,
// runs it continuously, acks each timeout as a tick. `TIMER_SEQ_SNAPSHOT_EN adds a counter snapshot at stop.
module timer_tick_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] period,
    input  logic [15:0] tick_limit,
    output logic        busy,
    output logic        running,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        done,
`ifdef TIMER_SEQ_SNAPSHOT_EN
    output logic [31:0] remaining,
`endif
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] WR_PL     = 4'd1;
    localparam logic [3:0] WR_PH     = 4'd2;
    localparam logic [3:0] GAP       = 4'd3;
    localparam logic [3:0] WR_CTRL   = 4'd4;
    localparam logic [3:0] RUN       = 4'd5;
    localparam logic [3:0] ACK       = 4'd6;
    localparam logic [3:0] STOP_CTRL = 4'd7;
    localparam logic [3:0] FIN       = 4'd8;
    localparam logic [3:0] SNAP_WR   = 4'd9;
    localparam logic [3:0] SNAP_RL   = 4'd10;
    localparam logic [3:0] SNAP_RH   = 4'd11;
    localparam logic [3:0] SNAP_CAP  = 4'd12;

    logic [3:0]  state, state_nxt;
    logic [31:0] period_q;
    logic [15:0] limit_q;
    logic        stop_lat;
    logic [15:0] count_inc;
    logic        limit_hit;

    assign count_inc = tick_count + 16'd1;
    assign limit_hit = (limit_q != 16'd0) && (count_inc == limit_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = WR_PL;
            WR_PL:     state_nxt = WR_PH;
            WR_PH:     state_nxt = GAP;
            GAP:       state_nxt = WR_CTRL;
            WR_CTRL:   state_nxt = RUN;
            // A timeout is always serviced before a pending stop so no tick is dropped
            RUN: begin
                if (tmr_irq)       state_nxt = ACK;
                else if (stop_lat) state_nxt = STOP_CTRL;
            end
            ACK:       state_nxt = (stop_lat || limit_hit) ? STOP_CTRL : RUN;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            STOP_CTRL: state_nxt = SNAP_WR;
            SNAP_WR:   state_nxt = SNAP_RL;
            SNAP_RL:   state_nxt = SNAP_RH;
            SNAP_RH:   state_nxt = SNAP_CAP;
            SNAP_CAP:  state_nxt = FIN;
`else
            STOP_CTRL: state_nxt = FIN;
`endif
            FIN:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            period_q   <= 32'd0;
            limit_q    <= 16'd0;
            stop_lat   <= 1'b0;
            tick_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (start) begin
                    // Below 3 the interval would not cover the ACK round trip
                    period_q   <= (period < 32'd3) ? 32'd3 : period;
                    limit_q    <= tick_limit;
                    tick_count <= 16'd0;
                    stop_lat   <= 1'b0;
                end
            end else if (stop) begin
                stop_lat <= 1'b1;
            end
            if (state == ACK) tick_count <= count_inc;
        end
    end

`ifdef TIMER_SEQ_SNAPSHOT_EN
    // Read latency is 1, so each half arrives in the state after its read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= 32'd0;
        end else begin
            if (state == SNAP_RH)  remaining[15:0]  <= tmr_readdata;
            if (state == SNAP_CAP) remaining[31:16] <= tmr_readdata;
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^tmr_readdata;
`endif

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'd0;
        case (state)
            WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd2;
                tmr_writedata  = period_q[15:0];
            end
            WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd3;
                tmr_writedata  = period_q[31:16];
            end
            WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0007;
            end
            ACK: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
            end
            STOP_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0008;
            end
`ifdef TIMER_SEQ_SNAPSHOT_EN
            SNAP_WR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd4;
            end
            SNAP_RL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd4;
            end
            SNAP_RH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd5;
            end
`endif
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign running = (state == RUN) || (state == ACK);
    assign tick    = (state == ACK);
    assign done    = (state == FIN);

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// Scoreboard bench for timer_tick_sequencer with a behavioural interval-timer model
// on the s1 side; expected bus writes, ticks and done pulses carry cycle deltas.
module tb_timer_tick_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period = 32'd0;
    logic [15:0] tick_limit = 16'd0;
    logic        busy, running, tick, done;
    logic [15:0] tick_count;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect, tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic [31:0] remaining;
`endif

    timer_tick_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .period(period), .tick_limit(tick_limit),
        .busy(busy), .running(running), .tick(tick), .tick_count(tick_count), .done(done),
`ifdef TIMER_SEQ_SNAPSHOT_EN
        .remaining(remaining),
`endif
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;

    // Interval timer model: period+1 cycles per timeout, read latency 1
    logic [31:0] m_period, m_cnt, m_snap;
    logic        m_run, m_cont, m_ito, m_to;
    logic        bus_wr, bus_rd;
    assign bus_wr  = tmr_chipselect && !tmr_write_n;
    assign bus_rd  = tmr_chipselect && tmr_write_n;
    assign tmr_irq = m_to && m_ito;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_period <= 0; m_cnt <= 0; m_snap <= 0;
            m_run <= 0; m_cont <= 0; m_ito <= 0; m_to <= 0;
            tmr_readdata <= 0;
        end else begin
            tmr_readdata <= 16'd0;
            if (bus_rd && tmr_address == 3'd4) tmr_readdata <= m_snap[15:0];
            if (bus_rd && tmr_address == 3'd5) tmr_readdata <= m_snap[31:16];
            if (m_run && !(bus_wr && tmr_address == 3'd1)) begin
                if (m_cnt == 0) begin
                    m_to  <= 1'b1;
                    m_cnt <= m_period;
                    if (!m_cont) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (bus_wr) begin
                case (tmr_address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito  <= tmr_writedata[0];
                        m_cont <= tmr_writedata[1];
                        if (tmr_writedata[2]) begin m_run <= 1'b1; m_cnt <= m_period; end
                        if (tmr_writedata[3]) m_run <= 1'b0;
                    end
                    3'd2: m_period[15:0]  <= tmr_writedata;
                    3'd3: m_period[31:16] <= tmr_writedata;
                    3'd4, 3'd5: m_snap <= m_cnt;
                    default: ;
                endcase
            end
        end
    end

    typedef struct {
        logic [1:0]  kind;   // 0 write, 1 tick, 2 done
        logic [2:0]  addr;
        logic [15:0] data;   // write data, or expected tick_count after the tick
        int          dly;    // cycles since previous event (or start); -1 = don't care
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  last_t = 0;
    logic        cnt_pend = 1'b0;
    logic [15:0] cnt_exp = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic [1:0] k, input logic [2:0] a, input logic [15:0] d, input int dl);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.dly = dl;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input logic [1:0] k, input logic [2:0] a, input logic [15:0] d);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d addr=%0d data=%h at cycle %0d, required none", k, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == 2'd0 && (e.addr != a || e.data != d)) ||
                (e.dly >= 0 && (cyc - last_t) != e.dly)) begin
                n_fail++;
                $display("FAIL event kind=%0d addr=%0d data=%h dly=%0d, required kind=%0d addr=%0d data=%h dly=%0d",
                         k, a, d, cyc - last_t, e.kind, e.addr, e.data, e.dly);
            end
            if (k == 2'd1) begin cnt_pend = 1'b1; cnt_exp = e.data; end
        end
        last_t = cyc;
    endtask

    // Monitor: compares every DUT-presented event against the queue head
    always @(negedge clk) begin
        if (!reset_n) begin
            cnt_pend = 1'b0;
        end else begin
            if (cnt_pend) begin
                n_chk++;
                if (tick_count !== cnt_exp) begin
                    n_fail++;
                    $display("FAIL tick_count got %0d, required %0d", tick_count, cnt_exp);
                end
                cnt_pend = 1'b0;
            end
            if (start && !busy) last_t = cyc;
            if (bus_wr) check_ev(2'd0, tmr_address, tmr_writedata);
            if (tick)   check_ev(2'd1, 3'd0, 16'd0);
            if (done)   check_ev(2'd2, 3'd0, 16'd0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start pulse in cycle 0; returns 1 ns into cycle 1
    task automatic do_start(input logic [31:0] p, input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1; period = p; tick_limit = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got %0d pending events, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic prog_writes(input logic [15:0] lo, input logic [15:0] hi);
        push(2'd0, 3'd2, lo, 1);
        push(2'd0, 3'd3, hi, 1);
        push(2'd0, 3'd1, 16'h0007, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_write_n", {31'd0, tmr_write_n}, 1);
        chk("reset_cs", {31'd0, tmr_chipselect}, 0);
        chk("reset_tick_count", {16'd0, tick_count}, 0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(2);

        // Free-run, period 9: ticks every 10 cycles, stop in cycle 40
        prog_writes(16'd9, 16'd0);
        for (int k = 1; k <= 3; k++) begin
            push(2'd0, 3'd0, 16'd0, (k == 1) ? 12 : 10);
            push(2'd1, 3'd0, 16'(k), 0);
        end
        push(2'd0, 3'd1, 16'h0008, 6);
        push(2'd2, 3'd0, 16'd0, 1);
        do_start(32'd9, 16'd0);
        wait_cyc(2);
        chk("gap_busy", {31'd0, busy}, 1);
        chk("gap_running", {31'd0, running}, 0);
        wait_cyc(3);
        chk("run_running", {31'd0, running}, 1);
        wait_cyc(34);
        pulse_stop();
        wait_cyc(10);
        chk("t1_busy", {31'd0, busy}, 0);
        drain("free_run");

        // Tick limit 3: auto-stop after the third tick
        prog_writes(16'd9, 16'd0);
        for (int k = 1; k <= 3; k++) begin
            push(2'd0, 3'd0, 16'd0, (k == 1) ? 12 : 10);
            push(2'd1, 3'd0, 16'(k), 0);
        end
        push(2'd0, 3'd1, 16'h0008, 1);
        push(2'd2, 3'd0, 16'd0, 1);
        do_start(32'd9, 16'd3);
        wait_cyc(45);
        chk("limit_busy", {31'd0, busy}, 0);
        chk("limit_count", {16'd0, tick_count}, 3);
        drain("limit");

        // stop coincident with irq in cycle 25: tick 2 still counted
        prog_writes(16'd9, 16'd0);
        push(2'd0, 3'd0, 16'd0, 12); push(2'd1, 3'd0, 16'd1, 0);
        push(2'd0, 3'd0, 16'd0, 10); push(2'd1, 3'd0, 16'd2, 0);
        push(2'd0, 3'd1, 16'h0008, 1);
        push(2'd2, 3'd0, 16'd0, 1);
        do_start(32'd9, 16'd0);
        wait_cyc(24);
        chk("coinc_irq", {31'd0, tmr_irq}, 1);
        pulse_stop();
        wait_cyc(30);
        chk("coinc_count", {16'd0, tick_count}, 2);
        chk("coinc_busy", {31'd0, busy}, 0);
        drain("coincident");

        // period 1 clamps to 3: 4-cycle interval, 100 ticks, none missed
        prog_writes(16'd3, 16'd0);
        for (int k = 1; k <= 100; k++) begin
            push(2'd0, 3'd0, 16'd0, (k == 1) ? 6 : 4);
            push(2'd1, 3'd0, 16'(k), 0);
        end
        push(2'd0, 3'd1, 16'h0008, 1);
        push(2'd2, 3'd0, 16'd0, 1);
        do_start(32'd1, 16'd100);
        wait_cyc(420);
        chk("clamp_count", {16'd0, tick_count}, 100);
        chk("clamp_busy", {31'd0, busy}, 0);
        drain("clamp");

        // Reset asserted during the first ACK
        prog_writes(16'd9, 16'd0);
        do_start(32'd9, 16'd0);
        wait_cyc(15);
        chk("pre_reset_tick", {31'd0, tick}, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_running", {31'd0, running}, 0);
        chk("arst_tick", {31'd0, tick}, 0);
        chk("arst_cs", {31'd0, tmr_chipselect}, 0);
        chk("arst_write_n", {31'd0, tmr_write_n}, 1);
        chk("arst_tick_count", {16'd0, tick_count}, 0);
        drain("pre_reset");
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(2);

        // Normal operation after reset: period 4, limit 2
        prog_writes(16'd4, 16'd0);
        push(2'd0, 3'd0, 16'd0, 7); push(2'd1, 3'd0, 16'd1, 0);
        push(2'd0, 3'd0, 16'd0, 5); push(2'd1, 3'd0, 16'd2, 0);
        push(2'd0, 3'd1, 16'h0008, 1);
        push(2'd2, 3'd0, 16'd0, 1);
        do_start(32'd4, 16'd2);
        wait_cyc(30);
        chk("post_reset_count", {16'd0, tick_count}, 2);
        chk("post_reset_busy", {31'd0, busy}, 0);
        drain("post_reset");

`ifdef TIMER_SEQ_SNAPSHOT_EN
        // Snapshot: stopped in cycle 22 with counter 0x10000-17
        prog_writes(16'h0000, 16'h0001);
        push(2'd0, 3'd1, 16'h0008, 18);
        push(2'd0, 3'd4, 16'h0000, 1);
        push(2'd2, 3'd0, 16'd0, 4);
        do_start(32'h0001_0000, 16'd0);
        wait_cyc(19);
        pulse_stop();
        wait_cyc(15);
        chk("snap_remaining", remaining, 32'h0000_FFEF);
        chk("snap_below", {31'd0, remaining < 32'h0001_0000}, 1);
        drain("snapshot");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
